// File: rtl/riscv_ctrl_pipe.sv
// Control unit for the 5-stage RV32I(+M) core: combinational decode in D,
// control/rd pipeline through E/M/W, load-use detection and md_unit sequencing.
module riscv_ctrl_pipe #(
    parameter bit ENABLE_M       = 1'b1,
    parameter bit ILLEGAL_BUBBLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_D,
    input  logic        flush_D_to_E,
    input  logic        md_done,
    output logic        jump_D,
    output logic        branch_D,
    output logic [2:0]  brfunct_D,
    output logic [2:0]  immcontrol_D,
    output logic        illegal_D,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        regwrite_E,
    output logic        regwrite_M,
    output logic        regwrite_W,
    output logic        memtoreg_E,
    output logic        memtoreg_M,
    output logic        memtoreg_W,
    output logic        load_imm_E,
    output logic        auipc_E,
    output logic        alusrc_E,
    output logic [3:0]  alucontrol_E,
    output logic        md_E,
    output logic [2:0]  md_op_E,
    output logic        md_start,
    output logic        memwrite_M,
    output logic        memen_M,
    output logic [2:0]  memsize_M,
    output logic [4:0]  rd_E,
    output logic [4:0]  rd_M,
    output logic [4:0]  rd_W
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       memen;
        logic       load_imm;
        logic       auipc;
        logic       alusrc;
        logic       md;
        logic [3:0] alucontrol;
        logic [2:0] md_op;
        logic [2:0] memsize;
        logic [4:0] rd;
    } ctrl_e_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       lu;
    logic       md_stall;
    ctrl_e_t    dec_D;
    ctrl_e_t    ctrl_E;
    md_state_t  state;
    md_state_t  state_nxt;

    assign opcode = instr_D[6:0];
    assign rd     = instr_D[11:7];
    assign funct3 = instr_D[14:12];
    assign rs1    = instr_D[19:15];
    assign rs2    = instr_D[24:20];
    assign funct7 = instr_D[31:25];

    assign brfunct_D = funct3;

    always_comb begin
        dec_D        = '0;
        jump_D       = 1'b0;
        branch_D     = 1'b0;
        immcontrol_D = 3'b000;
        illegal_D    = 1'b0;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_D.regwrite = 1'b1;
                dec_D.load_imm = 1'b1;
                dec_D.auipc    = (opcode == OP_AUIPC);
                immcontrol_D   = 3'b011;
            end
            OP_JAL: begin
                jump_D         = 1'b1;
                dec_D.regwrite = 1'b1;
                immcontrol_D   = 3'b100;
            end
            OP_JALR: begin
                jump_D         = 1'b1;
                dec_D.regwrite = 1'b1;
                uses_rs1       = 1'b1;
            end
            OP_BRANCH: begin
                branch_D     = 1'b1;
                immcontrol_D = 3'b010;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
            end
            OP_LOAD: begin
                dec_D.regwrite = 1'b1;
                dec_D.alusrc   = 1'b1;
                dec_D.memtoreg = 1'b1;
                dec_D.memen    = 1'b1;
                dec_D.memsize  = funct3;
                uses_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec_D.alusrc   = 1'b1;
                dec_D.memwrite = 1'b1;
                dec_D.memen    = 1'b1;
                dec_D.memsize  = funct3;
                immcontrol_D   = 3'b001;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
            end
            OP_IMM: begin
                dec_D.regwrite   = 1'b1;
                dec_D.alusrc     = 1'b1;
                // Only shift-right immediates carry an ALU op bit in funct7
                dec_D.alucontrol = {(funct3 == 3'b101) & funct7[5], funct3};
                uses_rs1         = 1'b1;
            end
            OP_REG: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (funct7 == 7'b0000001) begin
                    if (ENABLE_M) begin
                        dec_D.regwrite = 1'b1;
                        dec_D.md       = 1'b1;
                        dec_D.md_op    = funct3;
                    end else begin
                        illegal_D = 1'b1;
                    end
                end else begin
                    dec_D.regwrite   = 1'b1;
                    dec_D.alucontrol = {funct7[5], funct3};
                end
            end
            default: illegal_D = 1'b1;
        endcase
        dec_D.rd = (opcode == OP_BRANCH || opcode == OP_STORE) ? 5'd0 : rd;
    end

    assign lu = ctrl_E.memtoreg && (ctrl_E.rd != 5'd0) &&
                ((uses_rs1 && rs1 == ctrl_E.rd) || (uses_rs2 && rs2 == ctrl_E.rd));

    assign md_stall = ctrl_E.md && (state != MD_DONE);
    assign stall_E  = md_stall;
    assign stall_D  = md_stall | lu;
    assign stall_F  = md_stall | lu;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MD_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        md_start  = 1'b0;
        case (state)
            MD_IDLE: if (ctrl_E.md) begin
                md_start  = 1'b1;
                state_nxt = MD_BUSY;
            end
            MD_BUSY: if (md_done) state_nxt = MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // D -> E: a pending redirect is dropped while E holds; its source re-asserts it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_E <= '0;
        end else if (!stall_E) begin
            if (lu || flush_D_to_E || (illegal_D && ILLEGAL_BUBBLE)) ctrl_E <= '0;
            else                                                    ctrl_E <= dec_D;
        end
    end

    // E -> M
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || stall_E) begin
            if (!rst) begin
                regwrite_M <= 1'b0;
                memtoreg_M <= 1'b0;
                memwrite_M <= 1'b0;
                memen_M    <= 1'b0;
                memsize_M  <= 3'b000;
                rd_M       <= 5'd0;
            end else begin
                regwrite_M <= 1'b0;
                memtoreg_M <= 1'b0;
                memwrite_M <= 1'b0;
                memen_M    <= 1'b0;
                memsize_M  <= 3'b000;
                rd_M       <= 5'd0;
            end
        end else begin
            regwrite_M <= ctrl_E.regwrite;
            memtoreg_M <= ctrl_E.memtoreg;
            memwrite_M <= ctrl_E.memwrite;
            memen_M    <= ctrl_E.memen;
            memsize_M  <= ctrl_E.memsize;
            rd_M       <= ctrl_E.rd;
        end
    end

    // M -> W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_W <= 1'b0;
            memtoreg_W <= 1'b0;
            rd_W       <= 5'd0;
        end else begin
            regwrite_W <= regwrite_M;
            memtoreg_W <= memtoreg_M;
            rd_W       <= rd_M;
        end
    end

    assign regwrite_E   = ctrl_E.regwrite;
    assign memtoreg_E   = ctrl_E.memtoreg;
    assign load_imm_E   = ctrl_E.load_imm;
    assign auipc_E      = ctrl_E.auipc;
    assign alusrc_E     = ctrl_E.alusrc;
    assign alucontrol_E = ctrl_E.alucontrol;
    assign md_E         = ctrl_E.md;
    assign md_op_E      = ctrl_E.md_op;
    assign rd_E         = ctrl_E.rd;

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
// Directed bench for riscv_ctrl_pipe: one M-enabled instance (illegal keeps rd)
// and one M-disabled instance (illegal enters E as a bubble) on shared inputs.
module tb_riscv_ctrl_pipe;

    localparam logic [31:0] I_NOP   = 32'h0000_0013;
    localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_BNE   = 32'h0020_9463; // bne x1,x2,+8
    localparam logic [31:0] I_SW    = 32'h0020_A223; // sw x2,4(x1)
    localparam logic [31:0] I_JAL   = 32'h0000_00EF; // jal x1,0
    localparam logic [31:0] I_LUI   = 32'h0000_0137; // lui x2,0
    localparam logic [31:0] I_AUIPC = 32'h0000_0117; // auipc x2,0
    localparam logic [31:0] I_LW5   = 32'h0001_2283; // lw x5,0(x2)
    localparam logic [31:0] I_ADD6  = 32'h0012_8333; // add x6,x5,x1
    localparam logic [31:0] I_LW0   = 32'h0001_2003; // lw x0,0(x2)
    localparam logic [31:0] I_ADD60 = 32'h0050_0333; // add x6,x0,x5
    localparam logic [31:0] I_MUL   = 32'h0220_81B3; // mul x3,x1,x2
    localparam logic [31:0] I_DIV4  = 32'h0220_C233; // div x4,x1,x2
    localparam logic [31:0] I_DIV5  = 32'h0220_C2B3; // div x5,x1,x2
    localparam logic [31:0] I_ILL   = 32'h0000_03FF; // opcode 1111111, rd=7

    logic        clk;
    logic        rst;
    logic [31:0] instr_D;
    logic        flush_D_to_E;
    logic        md_done;

    logic jump_D, branch_D, illegal_D, stall_F, stall_D, stall_E;
    logic [2:0] brfunct_D, immcontrol_D, md_op_E, memsize_M;
    logic regwrite_E, regwrite_M, regwrite_W, memtoreg_E, memtoreg_M, memtoreg_W;
    logic load_imm_E, auipc_E, alusrc_E, md_E, md_start, memwrite_M, memen_M;
    logic [3:0] alucontrol_E;
    logic [4:0] rd_E, rd_M, rd_W;

    logic n_jump_D, n_branch_D, n_illegal_D, n_stall_F, n_stall_D, n_stall_E;
    logic [2:0] n_brfunct_D, n_immcontrol_D, n_md_op_E, n_memsize_M;
    logic n_regwrite_E, n_regwrite_M, n_regwrite_W, n_memtoreg_E, n_memtoreg_M, n_memtoreg_W;
    logic n_load_imm_E, n_auipc_E, n_alusrc_E, n_md_E, n_md_start, n_memwrite_M, n_memen_M;
    logic [3:0] n_alucontrol_E;
    logic [4:0] n_rd_E, n_rd_M, n_rd_W;

    int n_cmp;
    int n_bad;

    logic [31:0] alu_ins [5] = '{32'h4020_81B3, 32'h4020_D1B3, 32'h4020_D193, 32'h0020_B1B3, 32'h0020_E1B3};
    logic [3:0]  alu_exp [5] = '{4'b1000, 4'b1101, 4'b1101, 4'b0011, 4'b0110};

    riscv_ctrl_pipe #(.ENABLE_M(1'b1), .ILLEGAL_BUBBLE(1'b0)) dut (
        .clk(clk), .rst(rst), .instr_D(instr_D), .flush_D_to_E(flush_D_to_E), .md_done(md_done),
        .jump_D(jump_D), .branch_D(branch_D), .brfunct_D(brfunct_D), .immcontrol_D(immcontrol_D),
        .illegal_D(illegal_D), .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .regwrite_E(regwrite_E), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
        .memtoreg_E(memtoreg_E), .memtoreg_M(memtoreg_M), .memtoreg_W(memtoreg_W),
        .load_imm_E(load_imm_E), .auipc_E(auipc_E), .alusrc_E(alusrc_E),
        .alucontrol_E(alucontrol_E), .md_E(md_E), .md_op_E(md_op_E), .md_start(md_start),
        .memwrite_M(memwrite_M), .memen_M(memen_M), .memsize_M(memsize_M),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W)
    );

    riscv_ctrl_pipe #(.ENABLE_M(1'b0), .ILLEGAL_BUBBLE(1'b1)) dut_nm (
        .clk(clk), .rst(rst), .instr_D(instr_D), .flush_D_to_E(flush_D_to_E), .md_done(md_done),
        .jump_D(n_jump_D), .branch_D(n_branch_D), .brfunct_D(n_brfunct_D), .immcontrol_D(n_immcontrol_D),
        .illegal_D(n_illegal_D), .stall_F(n_stall_F), .stall_D(n_stall_D), .stall_E(n_stall_E),
        .regwrite_E(n_regwrite_E), .regwrite_M(n_regwrite_M), .regwrite_W(n_regwrite_W),
        .memtoreg_E(n_memtoreg_E), .memtoreg_M(n_memtoreg_M), .memtoreg_W(n_memtoreg_W),
        .load_imm_E(n_load_imm_E), .auipc_E(n_auipc_E), .alusrc_E(n_alusrc_E),
        .alucontrol_E(n_alucontrol_E), .md_E(n_md_E), .md_op_E(n_md_op_E), .md_start(n_md_start),
        .memwrite_M(n_memwrite_M), .memen_M(n_memen_M), .memsize_M(n_memsize_M),
        .rd_E(n_rd_E), .rd_M(n_rd_M), .rd_W(n_rd_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (regwrite_E !== 1'b0) begin n_bad++; $display("FAIL rst regwrite_E got %0b exp 0", regwrite_E); end
        n_cmp++; if (rd_M !== 5'd0) begin n_bad++; $display("FAIL rst rd_M got %0d exp 0", rd_M); end
        n_cmp++; if (rd_W !== 5'd0) begin n_bad++; $display("FAIL rst rd_W got %0d exp 0", rd_W); end
        n_cmp++; if (md_start !== 1'b0) begin n_bad++; $display("FAIL rst md_start got %0b exp 0", md_start); end
        n_cmp++; if (stall_D !== 1'b0) begin n_bad++; $display("FAIL rst stall_D got %0b exp 0", stall_D); end
        rst = 1'b1;
        instr_D = I_MUL;
        tick();
        n_cmp++; if (md_start !== 1'b1) begin n_bad++; $display("FAIL rst pre mul md_start got %0b exp 1", md_start); end
        instr_D = I_NOP;
        tick();
        n_cmp++; if (md_E !== 1'b1) begin n_bad++; $display("FAIL rst busy md_E got %0b exp 1", md_E); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (md_E !== 1'b0) begin n_bad++; $display("FAIL rst async md_E got %0b exp 0", md_E); end
        n_cmp++; if (rd_E !== 5'd0) begin n_bad++; $display("FAIL rst async rd_E got %0d exp 0", rd_E); end
        n_cmp++; if (stall_E !== 1'b0) begin n_bad++; $display("FAIL rst async stall_E got %0b exp 0", stall_E); end
        n_cmp++; if (md_start !== 1'b0) begin n_bad++; $display("FAIL rst async md_start got %0b exp 0", md_start); end
        n_cmp++; if (regwrite_M !== 1'b0) begin n_bad++; $display("FAIL rst async regwrite_M got %0b exp 0", regwrite_M); end
        @(posedge clk);
        #1 rst = 1'b1;
        instr_D = I_ADDI;
        tick();
        n_cmp++; if (regwrite_E !== 1'b1) begin n_bad++; $display("FAIL addi regwrite_E got %0b exp 1", regwrite_E); end
        n_cmp++; if (alusrc_E !== 1'b1) begin n_bad++; $display("FAIL addi alusrc_E got %0b exp 1", alusrc_E); end
        n_cmp++; if (alucontrol_E !== 4'b0000) begin n_bad++; $display("FAIL addi alucontrol_E got %b exp 0000", alucontrol_E); end
        n_cmp++; if (rd_E !== 5'd1) begin n_bad++; $display("FAIL addi rd_E got %0d exp 1", rd_E); end
        n_cmp++; if (memtoreg_E !== 1'b0) begin n_bad++; $display("FAIL addi memtoreg_E got %0b exp 0", memtoreg_E); end
        instr_D = I_NOP;
        tick();
    endtask

    task automatic test_decode();
        instr_D = I_BNE;
        #1;
        n_cmp++; if (branch_D !== 1'b1) begin n_bad++; $display("FAIL bne branch_D got %0b exp 1", branch_D); end
        n_cmp++; if (brfunct_D !== 3'b001) begin n_bad++; $display("FAIL bne brfunct_D got %b exp 001", brfunct_D); end
        n_cmp++; if (immcontrol_D !== 3'b010) begin n_bad++; $display("FAIL bne immcontrol_D got %b exp 010", immcontrol_D); end
        n_cmp++; if (jump_D !== 1'b0) begin n_bad++; $display("FAIL bne jump_D got %0b exp 0", jump_D); end
        n_cmp++; if (illegal_D !== 1'b0) begin n_bad++; $display("FAIL bne illegal_D got %0b exp 0", illegal_D); end
        tick();
        n_cmp++; if (rd_E !== 5'd0) begin n_bad++; $display("FAIL bne rd_E got %0d exp 0", rd_E); end
        n_cmp++; if (regwrite_E !== 1'b0) begin n_bad++; $display("FAIL bne regwrite_E got %0b exp 0", regwrite_E); end
        instr_D = I_SW;
        #1;
        n_cmp++; if (immcontrol_D !== 3'b001) begin n_bad++; $display("FAIL sw immcontrol_D got %b exp 001", immcontrol_D); end
        tick();
        n_cmp++; if (rd_E !== 5'd0) begin n_bad++; $display("FAIL sw rd_E got %0d exp 0", rd_E); end
        n_cmp++; if (alusrc_E !== 1'b1) begin n_bad++; $display("FAIL sw alusrc_E got %0b exp 1", alusrc_E); end
        instr_D = I_JAL;
        #1;
        n_cmp++; if (jump_D !== 1'b1) begin n_bad++; $display("FAIL jal jump_D got %0b exp 1", jump_D); end
        n_cmp++; if (immcontrol_D !== 3'b100) begin n_bad++; $display("FAIL jal immcontrol_D got %b exp 100", immcontrol_D); end
        tick();
        n_cmp++; if (memwrite_M !== 1'b1) begin n_bad++; $display("FAIL sw memwrite_M got %0b exp 1", memwrite_M); end
        n_cmp++; if (memen_M !== 1'b1) begin n_bad++; $display("FAIL sw memen_M got %0b exp 1", memen_M); end
        n_cmp++; if (memsize_M !== 3'b010) begin n_bad++; $display("FAIL sw memsize_M got %b exp 010", memsize_M); end
        n_cmp++; if (regwrite_E !== 1'b1 || rd_E !== 5'd1) begin n_bad++; $display("FAIL jal E got rw=%0b rd=%0d exp rw=1 rd=1", regwrite_E, rd_E); end
        instr_D = I_LUI;
        #1;
        n_cmp++; if (immcontrol_D !== 3'b011) begin n_bad++; $display("FAIL lui immcontrol_D got %b exp 011", immcontrol_D); end
        tick();
        n_cmp++; if (load_imm_E !== 1'b1 || auipc_E !== 1'b0 || rd_E !== 5'd2) begin n_bad++; $display("FAIL lui E got li=%0b au=%0b rd=%0d exp li=1 au=0 rd=2", load_imm_E, auipc_E, rd_E); end
        instr_D = I_AUIPC;
        tick();
        n_cmp++; if (load_imm_E !== 1'b1 || auipc_E !== 1'b1) begin n_bad++; $display("FAIL auipc E got li=%0b au=%0b exp li=1 au=1", load_imm_E, auipc_E); end
        instr_D = I_NOP;
        tick();
    endtask

    task automatic test_alu();
        for (int i = 0; i < 5; i++) begin
            instr_D = alu_ins[i];
            tick();
            n_cmp++; if (alucontrol_E !== alu_exp[i]) begin n_bad++; $display("FAIL alu[%0d] alucontrol_E got %b exp %b", i, alucontrol_E, alu_exp[i]); end
        end
        instr_D = I_NOP;
        tick();
    endtask

    task automatic test_flush();
        instr_D = I_ADDI;
        flush_D_to_E = 1'b1;
        tick();
        flush_D_to_E = 1'b0;
        n_cmp++; if (regwrite_E !== 1'b0 || rd_E !== 5'd0) begin n_bad++; $display("FAIL flush E got rw=%0b rd=%0d exp rw=0 rd=0", regwrite_E, rd_E); end
        tick();
        n_cmp++; if (rd_E !== 5'd1) begin n_bad++; $display("FAIL after flush rd_E got %0d exp 1", rd_E); end
        instr_D = I_NOP;
        tick();
    endtask

    task automatic test_load_use();
        instr_D = I_LW5;
        tick();
        instr_D = I_ADD6;
        #1;
        n_cmp++; if (stall_D !== 1'b1 || stall_F !== 1'b1) begin n_bad++; $display("FAIL lu stall_D/F got %0b/%0b exp 1/1", stall_D, stall_F); end
        n_cmp++; if (stall_E !== 1'b0) begin n_bad++; $display("FAIL lu stall_E got %0b exp 0", stall_E); end
        tick();
        n_cmp++; if (regwrite_E !== 1'b0 || rd_E !== 5'd0) begin n_bad++; $display("FAIL lu bubble E got rw=%0b rd=%0d exp 0/0", regwrite_E, rd_E); end
        n_cmp++; if (rd_M !== 5'd5 || memtoreg_M !== 1'b1 || memsize_M !== 3'b010) begin n_bad++; $display("FAIL lu lw M got rd=%0d mtr=%0b sz=%b exp 5/1/010", rd_M, memtoreg_M, memsize_M); end
        n_cmp++; if (stall_D !== 1'b0) begin n_bad++; $display("FAIL lu second stall_D got %0b exp 0", stall_D); end
        tick();
        n_cmp++; if (rd_E !== 5'd6 || regwrite_E !== 1'b1) begin n_bad++; $display("FAIL lu add E got rd=%0d rw=%0b exp 6/1", rd_E, regwrite_E); end
        n_cmp++; if (rd_M !== 5'd0 || rd_W !== 5'd5 || memtoreg_W !== 1'b1) begin n_bad++; $display("FAIL lu M/W got rdM=%0d rdW=%0d mtrW=%0b exp 0/5/1", rd_M, rd_W, memtoreg_W); end
        instr_D = I_LW0;
        tick();
        instr_D = I_ADD60;
        #1;
        n_cmp++; if (stall_D !== 1'b0) begin n_bad++; $display("FAIL lw x0 stall_D got %0b exp 0", stall_D); end
        tick();
        n_cmp++; if (rd_E !== 5'd6) begin n_bad++; $display("FAIL lw x0 add rd_E got %0d exp 6", rd_E); end
        instr_D = I_NOP;
        tick();
    endtask

    task automatic test_mul();
        int stalls;
        int starts;
        int bubbles;
        stalls = 0; starts = 0; bubbles = 0;
        instr_D = I_MUL;
        tick();
        instr_D = I_NOP;
        for (int k = 0; k < 8; k++) begin
            stalls += int'(stall_E);
            starts += int'(md_start);
            if (regwrite_M === 1'b0 && rd_M === 5'd0 && memen_M === 1'b0) bubbles++;
            if (k == 0) begin
                n_cmp++; if (md_E !== 1'b1 || md_op_E !== 3'b000 || rd_E !== 5'd3) begin n_bad++; $display("FAIL mul E got md=%0b op=%b rd=%0d exp 1/000/3", md_E, md_op_E, rd_E); end
            end
            if (k == 5) begin
                n_cmp++; if (stall_E !== 1'b0 || stall_D !== 1'b0) begin n_bad++; $display("FAIL mul done stalls got E=%0b D=%0b exp 0/0", stall_E, stall_D); end
            end
            if (k == 6) begin
                n_cmp++; if (rd_M !== 5'd3 || regwrite_M !== 1'b1) begin n_bad++; $display("FAIL mul M at t+6 got rd=%0d rw=%0b exp 3/1", rd_M, regwrite_M); end
            end
            md_done = (k == 4);
            tick();
        end
        md_done = 1'b0;
        n_cmp++; if (starts != 1) begin n_bad++; $display("FAIL mul md_start cycles got %0d exp 1", starts); end
        n_cmp++; if (stalls != 5) begin n_bad++; $display("FAIL mul stall_E cycles got %0d exp 5", stalls); end
        n_cmp++; if (bubbles != 5) begin n_bad++; $display("FAIL mul M bubbles got %0d exp 5", bubbles); end
    endtask

    task automatic test_back_to_back();
        int starts;
        int first_at;
        int second_at;
        starts = 0; first_at = -1; second_at = -1;
        instr_D = I_DIV4;
        tick();
        instr_D = I_DIV5;
        for (int k = 0; k < 9; k++) begin
            if (md_start === 1'b1) begin
                starts++;
                if (starts == 1) first_at = k;
                else if (starts == 2) second_at = k;
            end
            if (k == 4) begin
                n_cmp++; if (rd_M !== 5'd4 || rd_E !== 5'd5) begin n_bad++; $display("FAIL b2b k4 got rdM=%0d rdE=%0d exp 4/5", rd_M, rd_E); end
                instr_D = I_NOP;
            end
            if (k == 8) begin
                n_cmp++; if (rd_M !== 5'd5) begin n_bad++; $display("FAIL b2b second div rd_M got %0d exp 5", rd_M); end
            end
            md_done = (k == 2) || (k == 6);
            flush_D_to_E = (k == 1) || (k == 5);
            tick();
        end
        md_done = 1'b0;
        flush_D_to_E = 1'b0;
        n_cmp++; if (starts != 2) begin n_bad++; $display("FAIL b2b start count got %0d exp 2", starts); end
        n_cmp++; if (first_at != 0 || second_at != 4) begin n_bad++; $display("FAIL b2b start cycles got %0d,%0d exp 0,4", first_at, second_at); end
    endtask

    task automatic test_md_done_early();
        int starts;
        starts = 0;
        instr_D = I_MUL;
        tick();
        instr_D = I_NOP;
        for (int k = 0; k < 6; k++) begin
            starts += int'(md_start);
            if (k == 3) begin
                n_cmp++; if (rd_M !== 5'd0) begin n_bad++; $display("FAIL early done rd_M k3 got %0d exp 0", rd_M); end
            end
            if (k == 4) begin
                n_cmp++; if (rd_M !== 5'd3) begin n_bad++; $display("FAIL early done rd_M k4 got %0d exp 3", rd_M); end
            end
            md_done = (k == 0) || (k == 2);
            tick();
        end
        md_done = 1'b0;
        n_cmp++; if (starts != 1) begin n_bad++; $display("FAIL early done start count got %0d exp 1", starts); end
    endtask

    task automatic test_illegal();
        instr_D = I_ILL;
        #1;
        n_cmp++; if (illegal_D !== 1'b1 || n_illegal_D !== 1'b1) begin n_bad++; $display("FAIL ill opcode illegal_D got %0b/%0b exp 1/1", illegal_D, n_illegal_D); end
        tick();
        n_cmp++; if (rd_E !== 5'd7 || regwrite_E !== 1'b0 || alucontrol_E !== 4'b0000) begin n_bad++; $display("FAIL ill keep-rd E got rd=%0d rw=%0b alu=%b exp 7/0/0000", rd_E, regwrite_E, alucontrol_E); end
        n_cmp++; if (n_rd_E !== 5'd0 || n_regwrite_E !== 1'b0) begin n_bad++; $display("FAIL ill bubble E got rd=%0d rw=%0b exp 0/0", n_rd_E, n_regwrite_E); end
        instr_D = I_MUL;
        #1;
        n_cmp++; if (n_illegal_D !== 1'b1 || illegal_D !== 1'b0) begin n_bad++; $display("FAIL mul nomd illegal_D got %0b (M on %0b) exp 1 (0)", n_illegal_D, illegal_D); end
        tick();
        n_cmp++; if (n_rd_E !== 5'd0 || n_regwrite_E !== 1'b0 || n_md_E !== 1'b0 || n_md_start !== 1'b0) begin n_bad++; $display("FAIL mul nomd E got rd=%0d rw=%0b md=%0b st=%0b exp all 0", n_rd_E, n_regwrite_E, n_md_E, n_md_start); end
        instr_D = I_NOP;
        tick();
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        instr_D = I_NOP;
        flush_D_to_E = 1'b0;
        md_done = 1'b0;
        test_reset();
        test_decode();
        test_alu();
        test_flush();
        test_load_use();
        test_mul();
        test_back_to_back();
        test_md_done_early();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
